// File: rtl/key_step_conditioner_if.sv
// ---------------------------------------------------------------------------
// key_step_conditioner_if
// Purpose : bundles the pushbutton input and the conditioned step outputs of
//           key_step_conditioner so the board top and the counter can pass
//           them around as one bundle.
// Signals :
//   key_n          raw pushbutton, asynchronous, 0 = pressed
//   key_level      debounced level, 1 = pressed
//   press_pulse    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//   step_pulse     press pulse OR auto-repeat pulse (counter enable)
// Modports:
//   master  the side that owns the button and consumes the pulses
//   slave   the conditioner itself
// ---------------------------------------------------------------------------
interface key_step_conditioner_if;
  logic key_n;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic step_pulse;

  modport master (
    output key_n,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  step_pulse
  );

  modport slave (
    input  key_n,
    output key_level,
    output press_pulse,
    output release_pulse,
    output step_pulse
  );
endinterface

// File: rtl/key_step_conditioner.sv
// ---------------------------------------------------------------------------
// key_step_conditioner
// Purpose : turns a raw active-low pushbutton into clean single-cycle step
//           pulses for the hex-display event counter. The button is
//           synchronised (two flops), debounced in both directions and, while
//           held, produces periodic auto-repeat steps.
// Ports   :
//   CLOCK_50  system clock, all logic on the rising edge
//   reset     synchronous, active-high
//   kif       key_step_conditioner_if.slave
//               key_n (in), key_level / press_pulse / release_pulse /
//               step_pulse (out, all registered)
// Parameters:
//   DEBOUNCE_CYCLES  clocks the input must be stable to accept a change (>=1)
//   HOLD_CYCLES      clocks from press_pulse to the first repeat (>=1)
//   REPEAT_CYCLES    clocks between later repeats (>=1)
//   REPEAT_EN        1 enables auto-repeat, 0 gives one step per press
// ---------------------------------------------------------------------------
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  key_step_conditioner_if.slave  kif
);

  // Counter widths cover the largest terminal value they must hold.
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_sync2;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_rep_phase;   // 0: waiting for first repeat, 1: periodic
  logic                r_key_level;
  logic                r_press;
  logic                r_release;
  logic                r_step;

  logic                w_pressed;
  logic [HOLD_W-1:0]   w_hold_last;
  logic                w_hold_hit;

  assign w_pressed   = ~r_sync2;
  assign w_hold_last = r_rep_phase ? REP_LAST : HOLD_LAST;
  assign w_hold_hit  = (r_hold_cnt == w_hold_last);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= RELEASED;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b0;
      r_key_level <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_step      <= 1'b0;
    end else begin
      r_sync1   <= kif.key_n;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_step    <= 1'b0;

      case (r_state)
        RELEASED: begin
          r_key_level <= 1'b0;
          if (w_pressed) begin
            r_state   <= PRESS_CHK;
            r_deb_cnt <= '0;
          end
        end

        PRESS_CHK: begin
          if (!w_pressed) begin
            // Bounce: drop back silently.
            r_state <= RELEASED;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state     <= HELD;
            r_hold_cnt  <= '0;
            r_rep_phase <= 1'b0;
            r_press     <= 1'b1;
            r_step      <= 1'b1;
            r_key_level <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end

        HELD: begin
          r_key_level <= 1'b1;
          // The repeat timer runs on every HELD cycle, including the one
          // that leaves for RELEASE_CHK; it reloads on each repeat so it
          // never wraps however long the key is held.
          if (REPEAT_EN) begin
            if (w_hold_hit) begin
              r_step      <= 1'b1;
              r_hold_cnt  <= '0;
              r_rep_phase <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          if (!w_pressed) begin
            r_state   <= RELEASE_CHK;
            r_deb_cnt <= '0;
          end
        end

        RELEASE_CHK: begin
          // Repeat timer is frozen here; a glitch shifts the schedule by
          // the cycles spent in this state.
          r_key_level <= 1'b1;
          if (w_pressed) begin
            r_state <= HELD;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state     <= RELEASED;
            r_release   <= 1'b1;
            r_key_level <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end

        default: r_state <= RELEASED;
      endcase
    end
  end

  assign kif.key_level     = r_key_level;
  assign kif.press_pulse   = r_press;
  assign kif.release_pulse = r_release;
  assign kif.step_pulse    = r_step;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Bench for key_step_conditioner: two instances (auto-repeat on / off) share
// the button and reset; both are compared every cycle against a run-length
// reference model, plus directed timing checks from the test plan.
module tb_key_step_conditioner;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;
  int   n_tot = 0;
  int   n_bad = 0;
  int   t = 0;

  always #5 clk = ~clk;

  key_step_conditioner_if kif1 ();
  key_step_conditioner_if kif0 ();
  assign kif1.key_n = key_n;
  assign kif0.key_n = key_n;

  key_step_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
                         .REPEAT_EN(1'b1)) dut1 (.CLOCK_50(clk), .reset(rst), .kif(kif1));
  key_step_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
                         .REPEAT_EN(1'b0)) dut0 (.CLOCK_50(clk), .reset(rst), .kif(kif0));

  // Reference model, index 0 = repeat enabled, 1 = repeat disabled.
  // Level flips once D+1 consecutive synchronised samples disagree with it;
  // held time accumulates only while the level is 1 and no disagreement run
  // is in progress.
  logic m_sy1 [2];
  logic m_sy2 [2];
  logic m_lvl [2];
  logic m_pr  [2];
  logic m_rl  [2];
  logic m_st  [2];
  int   m_run [2];
  int   m_acc [2];
  int   m_due [2];

  int st1_q[$];
  int rl1_q[$];
  int pr1_q[$];
  int st0_q[$];
  int pr0_q[$];
  int any1_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic s;
      logic held;
      s = ~m_sy2[i];
      m_pr[i] = 1'b0;
      m_rl[i] = 1'b0;
      m_st[i] = 1'b0;
      if (rst) begin
        m_sy1[i] = 1'b1; m_sy2[i] = 1'b1; m_lvl[i] = 1'b0;
        m_run[i] = 0; m_acc[i] = 0; m_due[i] = H;
      end else begin
        m_sy2[i] = m_sy1[i];
        m_sy1[i] = key_n;
        held = m_lvl[i] && (m_run[i] == 0);
        if (held && i == 0) begin
          m_acc[i]++;
          if (m_acc[i] == m_due[i]) begin
            m_st[i] = 1'b1; m_acc[i] = 0; m_due[i] = R;
          end
        end
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = s;
            m_run[i] = 0;
            if (s) begin
              m_pr[i] = 1'b1; m_st[i] = 1'b1; m_acc[i] = 0; m_due[i] = H;
            end else begin
              m_rl[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic kn, input logic rs);
    @(negedge clk);
    key_n = kn;
    rst   = rs;
    @(posedge clk);
    t++;
    model_edge();
    #1;
    chk("lvl1", int'(kif1.key_level),     int'(m_lvl[0]));
    chk("prs1", int'(kif1.press_pulse),   int'(m_pr[0]));
    chk("rel1", int'(kif1.release_pulse), int'(m_rl[0]));
    chk("stp1", int'(kif1.step_pulse),    int'(m_st[0]));
    chk("lvl0", int'(kif0.key_level),     int'(m_lvl[1]));
    chk("prs0", int'(kif0.press_pulse),   int'(m_pr[1]));
    chk("rel0", int'(kif0.release_pulse), int'(m_rl[1]));
    chk("stp0", int'(kif0.step_pulse),    int'(m_st[1]));
    if (kif1.step_pulse)    st1_q.push_back(t);
    if (kif1.release_pulse) rl1_q.push_back(t);
    if (kif1.press_pulse)   pr1_q.push_back(t);
    if (kif0.step_pulse)    st0_q.push_back(t);
    if (kif0.press_pulse)   pr0_q.push_back(t);
    if (kif1.step_pulse || kif1.press_pulse || kif1.release_pulse ||
        kif1.key_level) any1_q.push_back(t);
  endtask

  task automatic seg(input logic kn, input logic rs, input int n);
    for (int i = 0; i < n; i++) cyc(kn, rs);
  endtask

  // Time origin: the first key_n change of a test happens just after edge 0.
  task automatic begin_test();
    t = 0;
    st1_q.delete(); rl1_q.delete(); pr1_q.delete();
    st0_q.delete(); pr0_q.delete(); any1_q.delete();
  endtask

  task automatic chk_q(input string tag, input int q[$], input int exp[$]);
    chk({tag, "_n"}, q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < q.size()) ? q[i] : -1, exp[i]);
  endtask

  initial begin
    // 1. Reset with key held, outputs 0 during reset, fresh press after.
    seg(1'b0, 1'b1, 3);
    chk("rst_lvl", int'(kif1.key_level), 0);
    chk("rst_stp", int'(kif1.step_pulse), 0);
    begin_test();
    seg(1'b0, 1'b0, 9);
    chk_q("t1_press", pr1_q, '{7});
    seg(1'b1, 1'b0, 15);

    // 2. Clean press, 9 clocks low.
    begin_test();
    seg(1'b0, 1'b0, 9);
    seg(1'b1, 1'b0, 15);
    chk_q("t2_press", pr1_q, '{7});
    chk_q("t2_rel", rl1_q, '{16});

    // 3. Bounces: nothing may come out.
    begin_test();
    for (int i = 0; i < 5; i++) begin
      seg(1'b0, 1'b0, 3);
      seg(1'b1, 1'b0, 3);
    end
    seg(1'b1, 1'b0, 10);
    chk("t3_quiet", any1_q.size(), 0);

    // 4. Auto-repeat, 40 clocks low.
    begin_test();
    seg(1'b0, 1'b0, 40);
    seg(1'b1, 1'b0, 15);
    chk_q("t4_step", st1_q, '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41});
    chk_q("t4_press", pr1_q, '{7});
    chk_q("t4_rel", rl1_q, '{47});
    chk_q("t6_step0", st0_q, '{7});

    // 5. Release glitch of 2 clocks in HELD.
    begin_test();
    seg(1'b0, 1'b0, 12);
    seg(1'b1, 1'b0, 2);
    seg(1'b0, 1'b0, 10);
    seg(1'b1, 1'b0, 15);
    chk_q("t5_step", st1_q, '{7, 19, 22, 25});
    chk_q("t5_rel", rl1_q, '{31});

    // 6. Mid-press reset while key held.
    begin_test();
    seg(1'b0, 1'b0, 19);
    seg(1'b0, 1'b1, 3);
    chk("t6_rst_lvl", int'(kif0.key_level), 0);
    seg(1'b0, 1'b0, 15);
    seg(1'b1, 1'b0, 15);
    chk_q("t6_press0", pr0_q, '{7, 29});

    // Random runs against the model.
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0)
        seg($urandom_range(0, 1) != 0, 1'b1, $urandom_range(1, 3));
      seg($urandom_range(0, 1) != 0, 1'b0, $urandom_range(1, 25));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
